// File: rtl/piece_mover_pkg.sv
// Shared definitions for the piece mover: phase codes, piece codes,
// board geometry, spawn origin and the 2x2 shape helpers.
package piece_mover_pkg;

    localparam int BOARD_W    = 4;
    localparam int BOARD_H    = 8;
    localparam int BOARD_BITS = BOARD_W * BOARD_H;

    typedef enum logic [2:0] {
        ST_GEN      = 3'd0,
        ST_MOVE     = 3'd1,
        ST_CLEAR    = 3'd2,
        ST_OVER     = 3'd3,
        ST_NEWBOARD = 3'd4
    } phase_t;

    localparam logic [1:0] PIECE_DOT = 2'b00;
    localparam logic [1:0] PIECE_BAR = 2'b01;
    localparam logic [1:0] PIECE_BOX = 2'b10;
    localparam logic [1:0] PIECE_ELL = 2'b11;

    localparam logic signed [4:0] SPAWN_ROW = 5'sd0;
    localparam logic signed [4:0] SPAWN_COL = 5'sd1;

    // Occupied cells of the 2x2 box, bit index = dr*2 + dc.
    function automatic logic [3:0] shape_cells(input logic [1:0] shape);
        logic [3:0] cells;
        case (shape)
            PIECE_DOT: cells = 4'b0001;
            PIECE_BAR: cells = 4'b0011;
            PIECE_BOX: cells = 4'b1111;
            default:   cells = 4'b1101;
        endcase
        return cells;
    endfunction

    // Board mask of the shape placed at (row, col); off-board cells are dropped.
    function automatic logic [BOARD_BITS-1:0] place_cells(input logic [1:0] shape,
                                                          input logic signed [4:0] row,
                                                          input logic signed [4:0] col);
        logic [BOARD_BITS-1:0] m;
        logic [3:0]            cells;
        int                    r;
        int                    c;
        m     = '0;
        cells = shape_cells(shape);
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                r = int'(row) + dr;
                c = int'(col) + dc;
                if (cells[2'(dr * 2 + dc)] && r >= 0 && r < BOARD_H && c >= 0 && c < BOARD_W)
                    m[5'(r * BOARD_W + c)] = 1'b1;
            end
        end
        return m;
    endfunction

    // True when every occupied cell of the shape at (row, col) is on the board.
    function automatic logic cells_in_bounds(input logic [1:0] shape,
                                             input logic signed [4:0] row,
                                             input logic signed [4:0] col);
        logic       ok;
        logic [3:0] cells;
        int         r;
        int         c;
        ok    = 1'b1;
        cells = shape_cells(shape);
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                r = int'(row) + dr;
                c = int'(col) + dc;
                if (cells[2'(dr * 2 + dc)] && !(r >= 0 && r < BOARD_H && c >= 0 && c < BOARD_W))
                    ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/piece_mover_if.sv
// Bus between the piece mover and the clear/spawn stage plus the buttons.
interface piece_mover_if import piece_mover_pkg::*;;
    logic [BOARD_BITS-1:0] board_in;
    logic                  error_in;
    logic [1:0]            curr_piece;
    logic                  btn_left;
    logic                  btn_right;
    logic                  btn_drop;
    logic [BOARD_BITS-1:0] board_out;
    logic [2:0]            state;
    logic [7:0]            pieces_placed;

    modport master (
        output board_in, error_in, curr_piece, btn_left, btn_right, btn_drop,
        input  board_out, state, pieces_placed
    );

    modport slave (
        input  board_in, error_in, curr_piece, btn_left, btn_right, btn_drop,
        output board_out, state, pieces_placed
    );
endinterface

// File: rtl/piece_fit.sv
// Places a shape at a candidate origin and reports whether it fits:
// every cell on the board and none overlapping the settled board.
module piece_fit import piece_mover_pkg::*; (
    input  logic [1:0]            shape,
    input  logic signed [4:0]     row,
    input  logic signed [4:0]     col,
    input  logic [BOARD_BITS-1:0] settled,
    output logic [BOARD_BITS-1:0] mask,
    output logic                  fits
);

    // Candidate mask and legality are purely combinational.
    always_comb begin
        mask = place_cells(shape, row, col);
        fits = cells_in_bounds(shape, row, col) && ((mask & settled) == '0);
    end

endmodule

// File: rtl/piece_mover.sv
// Game-control and piece-motion stage: sequences the phases, owns the
// settled board and the active piece, and drives the composite board.
module piece_mover import piece_mover_pkg::*; #(
    parameter logic [7:0] DROP_TICKS = 8'd50,
    parameter int         SETTLE     = 2
) (
    input  logic         clka,
    input  logic         restart,
    piece_mover_if.slave bus
);

    localparam logic [7:0] GRAV_LAST   = DROP_TICKS - 8'd1;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    phase_t                state_q;
    logic [BOARD_BITS-1:0] settled_q;
    logic [BOARD_BITS-1:0] board_q;
    logic [7:0]            placed_q;
    logic [7:0]            grav_cnt_q;
    logic [7:0]            settle_cnt_q;
    logic [1:0]            shape_q;
    logic signed [4:0]     pr_q;
    logic signed [4:0]     pc_q;

    logic [BOARD_BITS-1:0] left_mask;
    logic [BOARD_BITS-1:0] right_mask;
    logic [BOARD_BITS-1:0] down_mask;
    logic                  left_fits;
    logic                  right_fits;
    logic                  down_fits;
    logic [BOARD_BITS-1:0] cur_mask;
    logic [BOARD_BITS-1:0] spawn_mask;
    logic                  grav_go;
    logic                  left_go;
    logic                  right_go;

    piece_fit u_fit_left (
        .shape   (shape_q),
        .row     (pr_q),
        .col     (pc_q - 5'sd1),
        .settled (settled_q),
        .mask    (left_mask),
        .fits    (left_fits)
    );

    piece_fit u_fit_right (
        .shape   (shape_q),
        .row     (pr_q),
        .col     (pc_q + 5'sd1),
        .settled (settled_q),
        .mask    (right_mask),
        .fits    (right_fits)
    );

    piece_fit u_fit_down (
        .shape   (shape_q),
        .row     (pr_q + 5'sd1),
        .col     (pc_q),
        .settled (settled_q),
        .mask    (down_mask),
        .fits    (down_fits)
    );

    // Move requests: gravity wins, opposing left/right cancel each other.
    always_comb begin
        cur_mask   = place_cells(shape_q, pr_q, pc_q);
        spawn_mask = place_cells(bus.curr_piece, SPAWN_ROW, SPAWN_COL);
        grav_go    = bus.btn_drop || (grav_cnt_q == GRAV_LAST);
        left_go    = bus.btn_left && !bus.btn_right;
        right_go   = bus.btn_right && !bus.btn_left;
    end

    // Phase sequencer; board_out is registered from the next-state board.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q      <= ST_NEWBOARD;
            settled_q    <= '0;
            board_q      <= '0;
            placed_q     <= '0;
            grav_cnt_q   <= '0;
            settle_cnt_q <= '0;
            shape_q      <= '0;
            pr_q         <= '0;
            pc_q         <= '0;
        end else begin
            case (state_q)
                ST_NEWBOARD: begin
                    settled_q    <= '0;
                    board_q      <= '0;
                    settle_cnt_q <= '0;
                    state_q      <= ST_GEN;
                end
                ST_GEN: begin
                    board_q <= settled_q;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= '0;
                        if (bus.error_in) begin
                            state_q <= ST_OVER;
                        end else begin
                            // The spawned piece becomes active; strip it from the settled board.
                            settled_q  <= bus.board_in & ~spawn_mask;
                            board_q    <= (bus.board_in & ~spawn_mask) | spawn_mask;
                            shape_q    <= bus.curr_piece;
                            pr_q       <= SPAWN_ROW;
                            pc_q       <= SPAWN_COL;
                            grav_cnt_q <= '0;
                            state_q    <= ST_MOVE;
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                ST_MOVE: begin
                    if (grav_go) begin
                        grav_cnt_q <= '0;
                        if (down_fits) begin
                            pr_q    <= pr_q + 5'sd1;
                            board_q <= settled_q | down_mask;
                        end else begin
                            // Landing: freeze the piece into the settled board.
                            settled_q    <= settled_q | cur_mask;
                            board_q      <= settled_q | cur_mask;
                            placed_q     <= placed_q + 8'd1;
                            settle_cnt_q <= '0;
                            state_q      <= ST_CLEAR;
                        end
                    end else begin
                        grav_cnt_q <= grav_cnt_q + 8'd1;
                        if (left_go && left_fits) begin
                            pc_q    <= pc_q - 5'sd1;
                            board_q <= settled_q | left_mask;
                        end else if (right_go && right_fits) begin
                            pc_q    <= pc_q + 5'sd1;
                            board_q <= settled_q | right_mask;
                        end
                    end
                end
                ST_CLEAR: begin
                    board_q <= settled_q;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= '0;
                        settled_q    <= bus.board_in;
                        board_q      <= bus.board_in;
                        state_q      <= ST_GEN;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                ST_OVER: begin
                    state_q <= ST_OVER;
                end
                default: begin
                    state_q <= ST_NEWBOARD;
                end
            endcase
        end
    end

    assign bus.board_out     = board_q;
    assign bus.state         = state_q;
    assign bus.pieces_placed = placed_q;

endmodule
